// File: rtl/jtag_debug_cmd_decoder_if.sv
// Bundle between the JTAG-side command source / consumer and the debug command decoder.
// The decoder connects through the slave modport; the driving side uses master.
interface jtag_debug_cmd_decoder_if #(
  parameter int unsigned DR_WIDTH   = 38,
  parameter int unsigned IR_WIDTH   = 2,
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic                vs_udr;
  logic                vs_uir;
  logic [IR_WIDTH-1:0] ir_in;
  logic [DR_WIDTH-1:0] sr;
  logic                cmd_ready;
  logic                clr_overflow;

  logic                cmd_valid;
  logic [DR_WIDTH-1:0] jdo;
  logic [IR_WIDTH-1:0] cmd_ir;
  logic                cmd_action;
  logic [CNT_W-1:0]    cmd_count;
  logic                uir_pulse;
  logic                overflow;

  modport master (
    output vs_udr, vs_uir, ir_in, sr, cmd_ready, clr_overflow,
    input  cmd_valid, jdo, cmd_ir, cmd_action, cmd_count, uir_pulse, overflow
  );

  modport slave (
    input  vs_udr, vs_uir, ir_in, sr, cmd_ready, clr_overflow,
    output cmd_valid, jdo, cmd_ir, cmd_action, cmd_count, uir_pulse, overflow
  );
endinterface

// File: rtl/jtag_debug_cmd_decoder.sv
// Synchronizes JTAG update strobes into clk and queues {ir_in, sr} captures in a
// first-word fall-through FIFO with sticky overflow reporting.
module jtag_debug_cmd_decoder #(
  parameter int unsigned DR_WIDTH    = 38,
  parameter int unsigned IR_WIDTH    = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  jtag_debug_cmd_decoder_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [IR_WIDTH-1:0] ir;
    logic [DR_WIDTH-1:0] dr;
  } cmd_t;

  logic [SYNC_STAGES-1:0] udr_sync_q;
  logic [SYNC_STAGES-1:0] uir_sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   udr_hist_q;
  logic                   uir_hist_q;
  logic                   udr_last;
  logic                   uir_last;
  logic                   fill_last;
  logic                   capture;
  logic                   uir_edge;

  assign udr_last  = udr_sync_q[SYNC_STAGES-1];
  assign uir_last  = uir_sync_q[SYNC_STAGES-1];
  assign fill_last = fill_q[SYNC_STAGES-1];

  // fill_q marks when the last sync stage holds a genuine post-reset sample, so a
  // strobe held high through reset release is never mistaken for a rising edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      udr_sync_q <= '0;
      uir_sync_q <= '0;
      fill_q     <= '0;
      udr_hist_q <= 1'b1;
      uir_hist_q <= 1'b1;
    end else begin
      udr_sync_q <= {udr_sync_q[SYNC_STAGES-2:0], bus.vs_udr};
      uir_sync_q <= {uir_sync_q[SYNC_STAGES-2:0], bus.vs_uir};
      fill_q     <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      udr_hist_q <= fill_last ? udr_last : 1'b1;
      uir_hist_q <= fill_last ? uir_last : 1'b1;
    end
  end

  assign capture  = fill_last & udr_last & ~udr_hist_q;
  assign uir_edge = fill_last & uir_last & ~uir_hist_q;

  cmd_t             mem_q [FIFO_DEPTH];
  cmd_t             head;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             full;
  logic             pop;
  logic             push;

  // A pop frees the slot in the same cycle, so a capture into a full FIFO is kept then.
  always_comb begin
    full     = (count_q == CNT_W'(FIFO_DEPTH));
    pop      = (count_q != '0) & bus.cmd_ready;
    push     = capture & (~full | pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (bus.clr_overflow)          ovf_d = 1'b0;
    if (capture && full && !pop)   ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      if (push) mem_q[wr_ptr_q] <= '{ir: bus.ir_in, dr: bus.sr};
    end
  end

  assign head           = mem_q[rd_ptr_q];
  assign bus.cmd_valid  = (count_q != '0);
  assign bus.jdo        = head.dr;
  assign bus.cmd_ir     = head.ir;
  assign bus.cmd_action = head.dr[DR_WIDTH-1];
  assign bus.cmd_count  = count_q;
  assign bus.uir_pulse  = uir_edge;
  assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_jtag_debug_cmd_decoder.sv
// Directed bench for jtag_debug_cmd_decoder: expected commands are queued as stimulus
// is driven and compared as the FIFO head is consumed.
module tb_jtag_debug_cmd_decoder;
  localparam int unsigned DW = 38;
  localparam int unsigned IW = 2;

  logic clk;
  logic reset_n;
  int   n_vec = 0;
  int   n_err = 0;

  logic [IW+DW-1:0] sb_q [$];

  jtag_debug_cmd_decoder_if #(.DR_WIDTH(DW), .IR_WIDTH(IW), .FIFO_DEPTH(4)) bus ();

  jtag_debug_cmd_decoder #(
    .DR_WIDTH(DW), .IR_WIDTH(IW), .SYNC_STAGES(2), .FIFO_DEPTH(4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [IW-1:0] ir, input logic [DW-1:0] d, input bit keep);
    bus.ir_in  = ir;
    bus.sr     = d;
    bus.vs_udr = 1'b1;
    if (keep) sb_q.push_back({ir, d});
    tick(6);
    bus.vs_udr = 1'b0;
    tick(6);
  endtask

  task automatic pop_check(input string tag);
    int               n = 0;
    logic [IW+DW-1:0] e;
    while (bus.cmd_valid !== 1'b1 && n < 20) begin
      tick(1);
      n++;
    end
    chk({tag, "_valid"}, 64'(bus.cmd_valid), 64'd1);
    e = (sb_q.size() != 0) ? sb_q.pop_front() : '1;
    chk({tag, "_jdo"},    64'(bus.jdo),        64'(e[DW-1:0]));
    chk({tag, "_ir"},     64'(bus.cmd_ir),     64'(e[IW+DW-1:DW]));
    chk({tag, "_action"}, 64'(bus.cmd_action), 64'(e[DW-1]));
    bus.cmd_ready = 1'b1;
    tick(1);
    bus.cmd_ready = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] r;
    int            uir_hits;

    reset_n          = 1'b0;
    bus.vs_udr       = 1'b0;
    bus.vs_uir       = 1'b0;
    bus.ir_in        = '0;
    bus.sr           = '0;
    bus.cmd_ready    = 1'b0;
    bus.clr_overflow = 1'b0;
    tick(3);
    chk("rst_valid",    64'(bus.cmd_valid),  64'd0);
    chk("rst_jdo",      64'(bus.jdo),        64'd0);
    chk("rst_ir",       64'(bus.cmd_ir),     64'd0);
    chk("rst_action",   64'(bus.cmd_action), 64'd0);
    chk("rst_count",    64'(bus.cmd_count),  64'd0);
    chk("rst_uir",      64'(bus.uir_pulse),  64'd0);
    chk("rst_overflow", 64'(bus.overflow),   64'd0);
    reset_n = 1'b1;
    tick(5);

    // Single command: cmd_valid must rise on the third edge after the strobe is seen.
    bus.ir_in  = 2'b01;
    bus.sr     = 38'h2_0000_00AB;
    bus.vs_udr = 1'b1;
    sb_q.push_back({2'b01, 38'h2_0000_00AB});
    tick(1);
    chk("lat_edge1", 64'(bus.cmd_valid), 64'd0);
    tick(1);
    chk("lat_edge2", 64'(bus.cmd_valid), 64'd0);
    tick(1);
    chk("lat_edge3", 64'(bus.cmd_valid), 64'd1);
    chk("single_count", 64'(bus.cmd_count), 64'd1);
    tick(3);
    bus.vs_udr = 1'b0;
    tick(6);
    chk("single_hold_jdo", 64'(bus.jdo), 64'h2_0000_00AB);
    pop_check("single");
    chk("single_empty", 64'(bus.cmd_valid), 64'd0);
    chk("single_count0", 64'(bus.cmd_count), 64'd0);

    // Overflow: fifth command is dropped.
    for (int i = 1; i <= 5; i++) send_cmd(IW'(i), DW'(i), i <= 4);
    chk("ovf_count", 64'(bus.cmd_count), 64'd4);
    chk("ovf_flag",  64'(bus.overflow),  64'd1);
    bus.clr_overflow = 1'b1;
    tick(1);
    bus.clr_overflow = 1'b0;
    chk("ovf_clear1", 64'(bus.overflow), 64'd0);

    // Dropped capture coinciding with a clear: the set must win.
    bus.ir_in  = 2'b11;
    bus.sr     = 38'h3F;
    bus.vs_udr = 1'b1;
    tick(2);
    bus.clr_overflow = 1'b1;
    tick(1);
    bus.clr_overflow = 1'b0;
    chk("prio_set_wins", 64'(bus.overflow), 64'd1);
    chk("prio_count",    64'(bus.cmd_count), 64'd4);
    bus.clr_overflow = 1'b1;
    tick(1);
    bus.clr_overflow = 1'b0;
    chk("prio_clear", 64'(bus.overflow), 64'd0);
    tick(3);
    bus.vs_udr = 1'b0;
    tick(6);
    for (int i = 0; i < 4; i++) pop_check($sformatf("drain%0d", i));
    chk("drain_empty", 64'(bus.cmd_valid), 64'd0);

    // Full FIFO with a pop in the capture cycle: the new command is accepted.
    for (int i = 1; i <= 4; i++) send_cmd(IW'(i), DW'(16 + i), 1'b1);
    bus.ir_in  = 2'b10;
    bus.sr     = DW'(21);
    bus.vs_udr = 1'b1;
    tick(2);
    chk("fp_head_jdo", 64'(bus.jdo), 64'(sb_q[0][DW-1:0]));
    void'(sb_q.pop_front());
    bus.cmd_ready = 1'b1;
    tick(1);
    bus.cmd_ready = 1'b0;
    sb_q.push_back({2'b10, DW'(21)});
    chk("fp_count",    64'(bus.cmd_count), 64'd4);
    chk("fp_overflow", 64'(bus.overflow),  64'd0);
    tick(3);
    bus.vs_udr = 1'b0;
    tick(6);
    for (int i = 0; i < 4; i++) pop_check($sformatf("fp_drain%0d", i));
    chk("fp_empty", 64'(bus.cmd_valid), 64'd0);

    // Strobe held high across reset release yields nothing; a fresh edge yields one.
    reset_n    = 1'b0;
    bus.vs_udr = 1'b1;
    tick(2);
    reset_n = 1'b1;
    tick(8);
    chk("rsthi_count", 64'(bus.cmd_count), 64'd0);
    chk("rsthi_valid", 64'(bus.cmd_valid), 64'd0);
    bus.vs_udr = 1'b0;
    tick(6);
    send_cmd(2'b10, {1'b1, 37'h0_1234_5678}, 1'b1);
    chk("rsthi_one", 64'(bus.cmd_count), 64'd1);
    send_cmd(2'b00, 38'h1, 1'b1);
    send_cmd(2'b01, 38'h2, 1'b1);
    chk("rst3_count", 64'(bus.cmd_count), 64'd3);
    reset_n = 1'b0;
    #1;
    chk("rstmid_count", 64'(bus.cmd_count), 64'd0);
    chk("rstmid_valid", 64'(bus.cmd_valid), 64'd0);
    sb_q.delete();
    tick(2);
    reset_n = 1'b1;
    tick(5);

    // UIR pulses: one cycle each, same latency as capture, FIFO untouched.
    send_cmd(2'b11, {1'b1, 37'h7}, 1'b1);
    uir_hits = 0;
    for (int p = 0; p < 3; p++) begin
      bus.vs_uir = 1'b1;
      tick(1);
      chk($sformatf("uir%0d_e1", p), 64'(bus.uir_pulse), 64'd0);
      tick(1);
      chk($sformatf("uir%0d_e2", p), 64'(bus.uir_pulse), 64'd1);
      tick(1);
      chk($sformatf("uir%0d_e3", p), 64'(bus.uir_pulse), 64'd0);
      for (int k = 0; k < 7; k++) begin
        if (k == 2) bus.vs_uir = 1'b0;
        tick(1);
        if (bus.uir_pulse === 1'b1) uir_hits++;
      end
    end
    chk("uir_extra", 64'(uir_hits), 64'd0);
    chk("uir_count", 64'(bus.cmd_count), 64'd1);
    pop_check("uir_cmd");

    // Pointer wrap: two entries kept in flight while ten push/pop pairs stream through.
    send_cmd(2'b01, 38'hA5, 1'b1);
    send_cmd(2'b10, 38'h5A, 1'b1);
    for (int i = 0; i < 10; i++) begin
      r = {6'($urandom), $urandom};
      send_cmd(2'($urandom), r, 1'b1);
      pop_check($sformatf("wrap%0d", i));
      chk($sformatf("wrap%0d_count", i), 64'(bus.cmd_count), 64'd2);
    end
    pop_check("wrap_tail0");
    pop_check("wrap_tail1");
    chk("wrap_empty", 64'(bus.cmd_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
